// File: rtl/hop_tracker.sv
// Hop tracker: stores the visible block rows, moves the character one lane per hop,
// times the scroll animation and checks the landing. Optional macro: HOP_JUMP_QUEUE_EN.
module hop_tracker #(
    parameter int NUM_LANES  = 7,
    parameter int NUM_LAYERS = 5,
    parameter int CHAR_LAYER = 3,
    parameter int START_LANE = 3,
    parameter int ANIM_MS    = 200,
    parameter int CNT_W      = 16,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int TICK_W    = (ANIM_MS > 1) ? $clog2(ANIM_MS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_module_en,
    input  logic                 i_one_ms_tick,
    input  logic                 i_jump_left,
    input  logic                 i_jump_right,
    input  logic [NUM_LANES-1:0] i_row_map_in,
    input  logic [NUM_LANES-1:0] i_row_type_in,
    output logic                 o_shift_start,
    output logic                 o_busy,
    output logic [LANE_W-1:0]    o_char_lane,
    output logic                 o_jump_fail,
    output logic [1:0]           o_fail_cause,
    output logic [CNT_W-1:0]     o_hop_count,
    output logic [1:0]           o_dbg_state
);

    // Requests are 1-cycle pulses with no ready: a request is taken only when the
    // tracker is IDLE (or buffered when the queue option is built), otherwise lost.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_CHECK  = 2'd2,
        S_FAILED = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_HAZARD = 2'b01;
    localparam logic [1:0] CAUSE_EDGE   = 2'b10;

    state_t               r_state;
    logic [NUM_LANES-1:0] r_map  [NUM_LAYERS];
    logic [NUM_LANES-1:0] r_type [NUM_LAYERS];
    logic [LANE_W-1:0]    r_lane;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic                 r_shift;
    logic                 r_busy;
    logic                 r_fail;
    logic [1:0]           r_cause;
    logic [CNT_W-1:0]     r_hops;

    logic w_req_valid;
    logic w_req_right;
    logic w_go;
    logic w_go_right;
    logic w_at_edge;
    logic w_hazard;
    logic w_last_tick;

    assign w_req_valid = i_jump_left ^ i_jump_right;
    assign w_req_right = i_jump_right;

`ifdef HOP_JUMP_QUEUE_EN
    logic r_q_valid;
    logic r_q_right;

    // A buffered request takes priority over a live one arriving in the same cycle.
    assign w_go       = r_q_valid | w_req_valid;
    assign w_go_right = r_q_valid ? r_q_right : w_req_right;
`else
    assign w_go       = w_req_valid;
    assign w_go_right = w_req_right;
`endif

    assign w_at_edge   = w_go_right ? (r_lane == LANE_W'(NUM_LANES - 1)) : (r_lane == '0);
    assign w_hazard    = r_map[CHAR_LAYER][r_lane] & r_type[CHAR_LAYER][r_lane];
    assign w_last_tick = (r_tick_cnt == TICK_W'(ANIM_MS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_module_en) begin
            r_state    <= S_IDLE;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                r_map[k]  <= '0;
                r_type[k] <= '0;
            end
            r_lane     <= LANE_W'(START_LANE);
            r_tick_cnt <= '0;
            r_shift    <= 1'b0;
            r_busy     <= 1'b0;
            r_fail     <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_hops     <= '0;
`ifdef HOP_JUMP_QUEUE_EN
            r_q_valid  <= 1'b0;
            r_q_right  <= 1'b0;
`endif
        end else begin
            r_shift <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef HOP_JUMP_QUEUE_EN
                    r_q_valid <= 1'b0;
`endif
                    if (w_go) begin
                        if (w_at_edge) begin
                            r_state <= S_FAILED;
                            r_busy  <= 1'b1;
                            r_fail  <= 1'b1;
                            r_cause <= CAUSE_EDGE;
                        end else begin
                            r_lane <= w_go_right ? (r_lane + 1'b1) : (r_lane - 1'b1);
                            for (int k = NUM_LAYERS - 1; k > 0; k--) begin
                                r_map[k]  <= r_map[k-1];
                                r_type[k] <= r_type[k-1];
                            end
                            r_map[0]   <= i_row_map_in;
                            r_type[0]  <= i_row_type_in;
                            r_shift    <= 1'b1;
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_MOVE;
                        end
                    end
                end

                S_MOVE: begin
`ifdef HOP_JUMP_QUEUE_EN
                    if (w_req_valid && !r_q_valid) begin
                        r_q_valid <= 1'b1;
                        r_q_right <= w_req_right;
                    end
`endif
                    if (i_one_ms_tick) begin
                        if (w_last_tick) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                S_CHECK: begin
`ifdef HOP_JUMP_QUEUE_EN
                    if (w_req_valid && !r_q_valid) begin
                        r_q_valid <= 1'b1;
                        r_q_right <= w_req_right;
                    end
`endif
                    if (w_hazard) begin
                        r_state <= S_FAILED;
                        r_fail  <= 1'b1;
                        r_cause <= CAUSE_HAZARD;
`ifdef HOP_JUMP_QUEUE_EN
                        r_q_valid <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_hops  <= r_hops + 1'b1;
                    end
                end

                S_FAILED: begin
                    r_state <= S_FAILED;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_shift_start = r_shift;
    assign o_busy        = r_busy;
    assign o_char_lane   = r_lane;
    assign o_jump_fail   = r_fail;
    assign o_fail_cause  = r_cause;
    assign o_hop_count   = r_hops;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_hop_tracker.sv
// Bench for hop_tracker: directed vector table for the hop/hazard/edge/abort sequences,
// then randomized traffic checked against a row-queue reference model.
module tb_hop_tracker;

  localparam int ANIM = 4;
  localparam int CHAR = 3;
  localparam int NL   = 7;

`ifdef HOP_JUMP_QUEUE_EN
  localparam bit Q_EN = 1'b1;
`else
  localparam bit Q_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        module_en;
  logic        tick;
  logic        jl;
  logic        jr;
  logic [6:0]  map_in;
  logic [6:0]  type_in;
  logic        shift_start;
  logic        busy;
  logic [2:0]  char_lane;
  logic        jump_fail;
  logic [1:0]  fail_cause;
  logic [15:0] hop_count;
  logic [1:0]  dbg_state;

  hop_tracker #(.ANIM_MS(ANIM)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_module_en   (module_en),
    .i_one_ms_tick (tick),
    .i_jump_left   (jl),
    .i_jump_right  (jr),
    .i_row_map_in  (map_in),
    .i_row_type_in (type_in),
    .o_shift_start (shift_start),
    .o_busy        (busy),
    .o_char_lane   (char_lane),
    .o_jump_fail   (jump_fail),
    .o_fail_cause  (fail_cause),
    .o_hop_count   (hop_count),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_err;
  int cur_idx;

  typedef struct {
    logic        jl, jr, tk, en;
    logic [6:0]  mp, tp;
    logic [2:0]  lane;
    logic        busy, fail;
    logic [1:0]  cause;
    logic        shift;
    logic [15:0] hops;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, cur_idx, act, exp);
    end
  endtask

  task automatic check_outputs(input logic [2:0] lane, input logic b, input logic f,
                               input logic [1:0] c, input logic s, input logic [15:0] h);
    check("char_lane", 32'(char_lane), 32'(lane));
    check("busy", 32'(busy), 32'(b));
    check("jump_fail", 32'(jump_fail), 32'(f));
    check("fail_cause", 32'(fail_cause), 32'(c));
    check("shift_start", 32'(shift_start), 32'(s));
    check("hop_count", 32'(hop_count), 32'(h));
    check("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(b));
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic apply(input logic r, input logic e, input logic l, input logic rr,
                       input logic t, input logic [6:0] m, input logic [6:0] ty);
    @(negedge clk);
    rst_n = r; module_en = e; jl = l; jr = rr; tick = t; map_in = m; type_in = ty;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic l, input logic r, input logic t, input logic e,
                     input logic [6:0] m, input logic [6:0] ty,
                     input int lane, input logic b, input logic f, input logic [1:0] c,
                     input logic s, input int h);
    vec_t v;
    v.jl = l; v.jr = r; v.tk = t; v.en = e; v.mp = m; v.tp = ty;
    v.lane = 3'(lane); v.busy = b; v.fail = f; v.cause = c; v.shift = s; v.hops = 16'(h);
    tbl.push_back(v);
  endtask

  // One complete hop: request, 4 ticks with a tick-less gap, then the landing check.
  task automatic add_hop(input bit right, input logic [6:0] m, input logic [6:0] ty,
                         input int lane_after, input int hops_before, input bit hazard);
    add(!right, right, 0, 1, m, ty, lane_after, 1, 0, 2'b00, 1, hops_before);
    add(0, 0, 1, 1, 0, 0, lane_after, 1, 0, 2'b00, 0, hops_before);
    add(0, 0, 0, 1, 0, 0, lane_after, 1, 0, 2'b00, 0, hops_before);
    add(0, 0, 1, 1, 0, 0, lane_after, 1, 0, 2'b00, 0, hops_before);
    add(0, 0, 1, 1, 0, 0, lane_after, 1, 0, 2'b00, 0, hops_before);
    add(0, 0, 1, 1, 0, 0, lane_after, 1, 0, 2'b00, 0, hops_before);
    if (hazard)
      add(0, 0, 0, 1, 0, 0, lane_after, 1, 1, 2'b01, 0, hops_before);
    else
      add(0, 0, 0, 1, 0, 0, lane_after, 0, 0, 2'b00, 0, hops_before + 1);
  endtask

  // reference model: rows as a queue, newest at the front
  logic [6:0] m_map[$];
  logic [6:0] m_type[$];
  int m_lane, m_hops, m_ticks_left;
  bit m_failed, m_check, m_shift;
  logic [1:0] m_cause;
  bit m_q_valid, m_q_right;

  task automatic model_clear();
    m_map = {}; m_type = {};
    for (int k = 0; k < 5; k++) begin
      m_map.push_back(7'd0);
      m_type.push_back(7'd0);
    end
    m_lane = 3; m_hops = 0; m_ticks_left = 0;
    m_failed = 0; m_check = 0; m_shift = 0; m_cause = 2'b00;
    m_q_valid = 0; m_q_right = 0;
  endtask

  task automatic model_capture(input bit live, input bit right);
    if (Q_EN && live && !m_q_valid) begin
      m_q_valid = 1;
      m_q_right = right;
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l, input bit rr,
                            input bit t, input logic [6:0] m, input logic [6:0] ty);
    bit live, go, go_right;
    if (!r || !e) begin
      model_clear();
      return;
    end
    m_shift = 0;
    live = (l != rr);
    if (m_failed) begin
    end else if (m_check) begin
      m_check = 0;
      model_capture(live, rr);
      if (m_map[CHAR][m_lane] && m_type[CHAR][m_lane]) begin
        m_failed = 1; m_cause = 2'b01; m_q_valid = 0;
      end else begin
        m_hops = (m_hops + 1) % 65536;
      end
    end else if (m_ticks_left > 0) begin
      model_capture(live, rr);
      if (t) begin
        m_ticks_left--;
        if (m_ticks_left == 0) m_check = 1;
      end
    end else begin
      go = live; go_right = rr;
      if (m_q_valid) begin
        go = 1; go_right = m_q_right; m_q_valid = 0;
      end
      if (go) begin
        if ((go_right && m_lane == NL - 1) || (!go_right && m_lane == 0)) begin
          m_failed = 1; m_cause = 2'b10;
        end else begin
          m_lane = go_right ? m_lane + 1 : m_lane - 1;
          m_map.push_front(m);  void'(m_map.pop_back());
          m_type.push_front(ty); void'(m_type.pop_back());
          m_shift = 1;
          m_ticks_left = ANIM;
        end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cur_idx = 0;
    rst_n = 1'b0; module_en = 1'b1; tick = 1'b0; jl = 1'b0; jr = 1'b0;
    map_in = '0; type_in = '0;

    // reset held two cycles
    apply(0, 1, 0, 0, 0, 7'd0, 7'd0);
    apply(0, 1, 1, 0, 1, 7'd0, 7'd0);
    check_outputs(3'd3, 0, 0, 2'b00, 0, 16'd0);

    // conflict and idle tick: no change
    add(1, 1, 0, 1, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    // safe hop, then plant a hazard at lane 2 that reaches row 3 three hops later
    add_hop(1, 7'd0, 7'd0, 4, 0, 0);
    add_hop(0, 7'b0000100, 7'b0000100, 3, 1, 0);
    add_hop(1, 7'b0001000, 7'b0000000, 4, 2, 0);
    add_hop(0, 7'b0010000, 7'b0010000, 3, 3, 0);
    add_hop(0, 7'd0, 7'd0, 2, 4, 1);
    // FAILED absorbs requests
    add(1, 0, 1, 1, 0, 0, 2, 1, 1, 2'b01, 0, 4);
    add(0, 1, 0, 1, 0, 0, 2, 1, 1, 2'b01, 0, 4);
    // disable clears, then walk left into the edge
    add(0, 0, 0, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    add_hop(0, 7'd0, 7'd0, 2, 0, 0);
    add_hop(0, 7'd0, 7'd0, 1, 1, 0);
    add_hop(0, 7'd0, 7'd0, 0, 2, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 1, 2'b10, 0, 3);
    add(0, 1, 0, 1, 0, 0, 0, 1, 1, 2'b10, 0, 3);
    // abort mid-MOVE
    add(0, 0, 0, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    add(0, 1, 0, 1, 0, 0, 4, 1, 0, 2'b00, 1, 0);
    add(0, 0, 1, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    // recovery, walk right into the right edge
    add_hop(1, 7'd0, 7'd0, 4, 0, 0);
    add_hop(1, 7'd0, 7'd0, 5, 1, 0);
    add_hop(1, 7'd0, 7'd0, 6, 2, 0);
    add(0, 1, 0, 1, 0, 0, 6, 1, 1, 2'b10, 0, 3);
    // request during MOVE: dropped, or replayed one cycle after IDLE with the buffer
    add(0, 0, 0, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    add(0, 1, 0, 1, 0, 0, 4, 1, 0, 2'b00, 1, 0);
    add(1, 0, 1, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
    add(0, 0, 0, 1, 0, 0, 4, 0, 0, 2'b00, 0, 1);
    if (Q_EN)
      add(0, 0, 0, 1, 0, 0, 3, 1, 0, 2'b00, 1, 1);
    else
      add(0, 0, 0, 1, 0, 0, 4, 0, 0, 2'b00, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      cur_idx = i + 1;
      apply(1, tbl[i].en, tbl[i].jl, tbl[i].jr, tbl[i].tk, tbl[i].mp, tbl[i].tp);
      check_outputs(tbl[i].lane, tbl[i].busy, tbl[i].fail, tbl[i].cause,
                    tbl[i].shift, tbl[i].hops);
    end

    // randomized traffic against the reference model
    apply(0, 1, 0, 0, 0, 7'd0, 7'd0);
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, rr, t;
      logic [6:0] m, ty;
      cur_idx = 10000 + i;
      r  = ($urandom_range(0, 199) != 0);
      e  = m_failed ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
      l  = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 4) == 0);
      t  = 1'($urandom_range(0, 1));
      m  = 7'($urandom);
      ty = 7'($urandom & $urandom);
      apply(r, e, l, rr, t, m, ty);
      model_step(r, e, l, rr, t, m, ty);
      check_outputs(3'(m_lane), m_failed || m_check || (m_ticks_left > 0), m_failed,
                    m_cause, m_shift, 16'(m_hops));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
